// File: rtl/svdb_csr_pkg.sv
// Shared types and register map for the SVDB CSR responder.
// The map table is the single source of offsets and access rights.
package svdb_csr_pkg;

    typedef enum logic [1:0] {ACC_RO, ACC_WO, ACC_RW} acc_e;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam logic [7:0] CTRL_OFS    = 8'h00;
    localparam logic [7:0] STATUS_OFS  = 8'h04;
    localparam logic [7:0] CMD_OFS     = 8'h08;
    localparam logic [7:0] SCRATCH_OFS = 8'h0C;

    localparam logic [1:0] IDX_CTRL    = 2'd0;
    localparam logic [1:0] IDX_STATUS  = 2'd1;
    localparam logic [1:0] IDX_CMD     = 2'd2;
    localparam logic [1:0] IDX_SCRATCH = 2'd3;

    typedef struct packed {
        logic [7:0]  offset;
        acc_e        acc;
        logic [31:0] reset;
    } reg_info_t;

    // Indexed by addr[3:2]; STATUS has no storage, so its reset field is unused.
    localparam reg_info_t REG_MAP [4] = '{
        '{offset: CTRL_OFS,    acc: ACC_RW, reset: 32'h0000_0000},
        '{offset: STATUS_OFS,  acc: ACC_RO, reset: 32'h0000_0000},
        '{offset: CMD_OFS,     acc: ACC_WO, reset: 32'h0000_0000},
        '{offset: SCRATCH_OFS, acc: ACC_RW, reset: 32'hDEAD_BEEF}
    };

    function automatic acc_e acc_of(input logic [1:0] idx);
        return REG_MAP[idx].acc;
    endfunction

endpackage

// File: rtl/svdb_csr_decode.sv
// Combinational address decode: byte address + direction -> register index, hit, error.
// An error covers misalignment, out-of-map addresses and writes to read-only registers.
module svdb_csr_decode
    import svdb_csr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_write,
    output logic [1:0]        o_idx,
    output logic              o_hit,
    output logic              o_err
);

    logic w_aligned;
    logic w_in_range;
    acc_e w_acc;

    always_comb begin
        o_idx      = i_addr[3:2];
        w_aligned  = (i_addr[1:0] == 2'b00);
        w_in_range = (i_addr <= ADDR_W'(SCRATCH_OFS));
        o_hit      = w_aligned && w_in_range;
        w_acc      = acc_of(o_idx);
        o_err      = !o_hit || (i_write && (w_acc == ACC_RO));
    end

endmodule

// File: rtl/svdb_csr_responder.sv
// Register-file responder: one request in flight, optional wait cycles, response held until taken.
// Writes and read sampling both happen on the accept edge; the response path only replays them.
module svdb_csr_responder
    import svdb_csr_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 32,
    parameter int                RD_LATENCY  = 1,
    parameter logic [DATA_W-1:0] SCRATCH_RST = DATA_W'(32'hDEADBEEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   ctrl_o,
    input  logic [DATA_W-1:0]   status_i,
    output logic                cmd_pulse_o,
    output logic [DATA_W-1:0]   cmd_data_o,
    output state_e              dbg_state_o
);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready (IDLE only);
    // a response transfers on a rising edge with rsp_valid && rsp_ready and is held until then.

    localparam logic [2:0] LAT_LOAD = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [2:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_scratch;
    logic [DATA_W-1:0] r_cmd_data;
    logic              r_cmd_pulse;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_wr_ok;
    logic [1:0]        w_idx;
    logic              w_hit;
    logic              w_err;
    logic [DATA_W-1:0] w_rd_data;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0]   old_v,
        input logic [DATA_W-1:0]   new_v,
        input logic [DATA_W/8-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    svdb_csr_decode #(.ADDR_W(ADDR_W)) u_decode (
        .i_addr  (req_addr),
        .i_write (req_write),
        .o_idx   (w_idx),
        .o_hit   (w_hit),
        .o_err   (w_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (RD_LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT:    if (r_lat_cnt == 3'd0) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // CMD is write-only and reads back as zero; errored accesses return zero too.
    always_comb begin
        w_wr_ok   = w_accept && req_write && w_hit && !w_err;
        w_rd_data = '0;
        if (!req_write && !w_err) begin
            case (w_idx)
                IDX_CTRL:    w_rd_data = r_ctrl;
                IDX_STATUS:  w_rd_data = status_i;
                IDX_SCRATCH: w_rd_data = r_scratch;
                default:     w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lat_cnt   <= 3'd0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_lat_cnt   <= LAT_LOAD;
                r_rsp_rdata <= w_rd_data;
                r_rsp_err   <= w_err;
            end else if (r_state == WAIT && r_lat_cnt != 3'd0) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl      <= '0;
            r_scratch   <= SCRATCH_RST;
            r_cmd_data  <= '0;
            r_cmd_pulse <= 1'b0;
        end else begin
            r_cmd_pulse <= w_wr_ok && (w_idx == IDX_CMD);
            if (w_wr_ok) begin
                case (w_idx)
                    IDX_CTRL:    r_ctrl     <= merge_bytes(r_ctrl, req_wdata, req_wstrb);
                    IDX_CMD:     r_cmd_data <= merge_bytes(r_cmd_data, req_wdata, req_wstrb);
                    IDX_SCRATCH: r_scratch  <= merge_bytes(r_scratch, req_wdata, req_wstrb);
                    default:     ;
                endcase
            end
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign ctrl_o      = r_ctrl;
    assign cmd_pulse_o = r_cmd_pulse;
    assign cmd_data_o  = r_cmd_data;
    assign dbg_state_o = r_state;

endmodule
